// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for a single-port data memory, with short burst lock and registered responses.
// Define DMEM_ARB_FIXED_PRIO_EN to make port 0 always win in free arbitration instead of round-robin.
module dmem_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int LOCK_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_0,
   output logic              req_ready_0,
   input  logic              req_we_0,
   input  logic              req_lock_0,
   input  logic [ADDR_W-1:0] req_addr_0,
   input  logic [DATA_W-1:0] req_wdata_0,
   output logic              rsp_valid_0,
   output logic [DATA_W-1:0] rsp_rdata_0,
   input  logic              req_valid_1,
   output logic              req_ready_1,
   input  logic              req_we_1,
   input  logic              req_lock_1,
   input  logic [ADDR_W-1:0] req_addr_1,
   input  logic [DATA_W-1:0] req_wdata_1,
   output logic              rsp_valid_1,
   output logic [DATA_W-1:0] rsp_rdata_1,
   output logic              mem_w_en,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] mem_rd_data
);

   localparam int CNT_W = $clog2(LOCK_MAX + 1);

   typedef enum logic [1:0] {
      ARB,
      LOCK0,
      LOCK1
   } state_t;

   state_t             r_state;
   state_t             w_stateNext;
   logic [CNT_W-1:0]   r_lockCnt;
   logic [CNT_W-1:0]   w_lockCntNext;
   logic               w_grant0;
   logic               w_grant1;
   logic               w_lockMore;
   logic               r_rspValid0;
   logic               r_rspValid1;
   logic [DATA_W-1:0]  r_rspRdata0;
   logic [DATA_W-1:0]  r_rspRdata1;

`ifndef DMEM_ARB_FIXED_PRIO_EN
   logic               r_rrLast;
`endif

   // Grants are suppressed during reset so no beat is accepted or written.
   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (!rst) begin
         case (r_state)
            ARB: begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
               w_grant0 = req_valid_0;
               w_grant1 = req_valid_1 & ~req_valid_0;
`else
               if (req_valid_0 && req_valid_1) begin
                  w_grant0 = r_rrLast;
                  w_grant1 = ~r_rrLast;
               end else begin
                  w_grant0 = req_valid_0;
                  w_grant1 = req_valid_1;
               end
`endif
            end
            LOCK0:   w_grant0 = req_valid_0;
            LOCK1:   w_grant1 = req_valid_1;
            default: ;
         endcase
      end
   end

   // A locked owner that goes idle releases the memory immediately.
   always_comb begin
      w_stateNext   = r_state;
      w_lockCntNext = r_lockCnt;
      w_lockMore    = (int'(r_lockCnt) + 1) < LOCK_MAX;
      case (r_state)
         ARB: begin
            if (LOCK_MAX > 1) begin
               if (w_grant0 && req_lock_0) begin
                  w_stateNext   = LOCK0;
                  w_lockCntNext = CNT_W'(1);
               end else if (w_grant1 && req_lock_1) begin
                  w_stateNext   = LOCK1;
                  w_lockCntNext = CNT_W'(1);
               end
            end
         end
         LOCK0: begin
            if (!w_grant0 || !req_lock_0 || !w_lockMore) begin
               w_stateNext   = ARB;
               w_lockCntNext = '0;
            end else begin
               w_lockCntNext = r_lockCnt + CNT_W'(1);
            end
         end
         LOCK1: begin
            if (!w_grant1 || !req_lock_1 || !w_lockMore) begin
               w_stateNext   = ARB;
               w_lockCntNext = '0;
            end else begin
               w_lockCntNext = r_lockCnt + CNT_W'(1);
            end
         end
         default: begin
            w_stateNext   = ARB;
            w_lockCntNext = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ARB;
         r_lockCnt <= '0;
      end else begin
         r_state   <= w_stateNext;
         r_lockCnt <= w_lockCntNext;
      end
   end

`ifndef DMEM_ARB_FIXED_PRIO_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rrLast <= 1'b1;
      end else if (w_grant0) begin
         r_rrLast <= 1'b0;
      end else if (w_grant1) begin
         r_rrLast <= 1'b1;
      end
   end
`endif

   // Read data is captured at the end of the accepting cycle; writes respond with zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rspValid0 <= 1'b0;
         r_rspValid1 <= 1'b0;
         r_rspRdata0 <= '0;
         r_rspRdata1 <= '0;
      end else begin
         r_rspValid0 <= w_grant0;
         r_rspValid1 <= w_grant1;
         if (w_grant0) begin
            r_rspRdata0 <= req_we_0 ? '0 : mem_rd_data;
         end
         if (w_grant1) begin
            r_rspRdata1 <= req_we_1 ? '0 : mem_rd_data;
         end
      end
   end

   assign req_ready_0 = w_grant0;
   assign req_ready_1 = w_grant1;
   assign mem_w_en    = (w_grant0 & req_we_0) | (w_grant1 & req_we_1);
   assign mem_address = w_grant1 ? req_addr_1 : req_addr_0;
   assign mem_wr_data = w_grant1 ? req_wdata_1 : req_wdata_0;

   // Responses are masked while reset is held so a pending beat is discarded.
   assign rsp_valid_0 = r_rspValid0 & ~rst;
   assign rsp_valid_1 = r_rspValid1 & ~rst;
   assign rsp_rdata_0 = rst ? '0 : r_rspRdata0;
   assign rsp_rdata_1 = rst ? '0 : r_rspRdata1;

endmodule
